csa_seq_multiplier: RTL and testbench

Parametrised iterative multiplier. It accumulates one partial-product row per clock into a carry-save (sum/carry) register pair, then resolves the result with a single carry-propagate add. It supports unsigned and signed (two's complement) operands, selected per transaction, and uses valid/ready handshakes on both the operand and product sides. It is the area-optimised, width-scalable successor to the fixed 4x4 combinational array multiplier, for datapaths that can tolerate multi-cycle latency.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/FA.sv | 15 +
 rtl/csa_row.sv | 25 ++
 rtl/csa_seq_multiplier.sv | 126 ++++++++++++
 tb/tb_csa_seq_multiplier.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier family: FSM state encoding and product width.
// Latency: none (package only).
// Backpressure: not applicable.
package mult_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_ACCUM   = ACCUM,
        ST_RESOLVE = RESOLVE,
        ST_DONE    = DONE
    } state_t;

    // Full-precision product width for a given operand width.
    function automatic int PROD_W(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/FA.sv
// Single-bit full adder: three equally weighted inputs to sum and carry.
// Latency: combinational.
// Backpressure: not applicable.
module FA (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_row.sv
// One 3:2 carry-save compressor row of N full adders; no carry propagation.
// Latency: combinational.
// Backpressure: not applicable.
module csa_row #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    // carry[i] carries weight 2^(i+1); the consumer shifts it left by one.
    for (genvar i = 0; i < N; i++) begin : g_fa
        FA u_fa (
            .x (x[i]),
            .y (y[i]),
            .z (z[i]),
            .s (sum[i]),
            .c (carry[i])
        );
    end

endmodule

// File: rtl/csa_seq_multiplier.sv
// Iterative signed/unsigned multiplier: one partial-product row per clock into a carry-save pair.
// Latency: WIDTH+1 cycles from operand accept to out_valid; one product per WIDTH+3 cycles at best.
// Backpressure: product held in DONE until out_ready; in_ready is low everywhere except IDLE.
module csa_seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW    = PROD_W(WIDTH);
    localparam int ROW_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WIDTH - 1);

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic              neg;
    logic [PW-1:0]     sum_q;
    logic [PW-1:0]     carry_q;
    logic [ROW_W-1:0]  row;

    logic [WIDTH-1:0]  a_abs_in;
    logic [WIDTH-1:0]  b_abs_in;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     carry_sh;
    logic [PW-1:0]     csa_sum;
    logic [PW-1:0]     csa_carry;
    logic [PW-1:0]     mag;

    // Magnitudes at capture; the most-negative value negates to 2^(WIDTH-1), which still fits unsigned.
    assign a_abs_in = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_abs_in = (signed_mode && b[WIDTH-1]) ? -b : b;

    // Current partial-product row, aligned to its weight.
    assign pp       = b_mag[row] ? (PW'(a_mag) << row) : '0;
    assign carry_sh = carry_q << 1;

    csa_row #(
        .N (PW)
    ) u_csa_row (
        .x     (sum_q),
        .y     (carry_sh),
        .z     (pp),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    // Final carry-propagate add; the true magnitude always fits in PW bits.
    assign mag = sum_q + carry_sh;

    // Outputs decode from the registered state only.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (in_valid)        state_nxt = ST_ACCUM;
            ST_ACCUM:   if (row == LAST_ROW) state_nxt = ST_RESOLVE;
            ST_RESOLVE:                      state_nxt = ST_DONE;
            ST_DONE:    if (out_ready)       state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture operands, accumulate rows in carry-save form, resolve and sign-correct.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mag   <= '0;
            b_mag   <= '0;
            neg     <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            row     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_mag   <= a_abs_in;
                        b_mag   <= b_abs_in;
                        neg     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sum_q   <= '0;
                        carry_q <= '0;
                        row     <= '0;
                    end
                end
                ST_ACCUM: begin
                    sum_q   <= csa_sum;
                    carry_q <= csa_carry;
                    row     <= row + ROW_W'(1);
                end
                ST_RESOLVE: begin
                    product <= neg ? -mag : mag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Self-checking bench for csa_seq_multiplier at WIDTH 8, 4 and 16.
// Latency: checks WIDTH+1 accept-to-valid latency per transaction.
// Backpressure: exercises held output under out_ready low and mid-operation reset.
module tb_csa_seq_multiplier;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    logic        sm;
    logic        out_ready;
    logic        iv8, iv4, iv16;

    logic        ir8, ov8, busy8;
    logic [15:0] p8;
    logic        ir4, ov4, busy4;
    logic [7:0]  p4;
    logic        ir16, ov16, busy16;
    logic [31:0] p16;

    csa_seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .signed_mode(sm),
        .out_valid(ov8), .out_ready(out_ready), .product(p8), .busy(busy8)
    );
    csa_seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .signed_mode(sm),
        .out_valid(ov4), .out_ready(out_ready), .product(p4), .busy(busy4)
    );
    csa_seq_multiplier #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .signed_mode(sm),
        .out_valid(ov16), .out_ready(out_ready), .product(p16), .busy(busy16)
    );

    // Currently selected instance.
    int          sel_w;
    logic        c_ir, c_ov, c_busy;
    logic [63:0] c_prod;

    always_comb begin
        c_ir = ir8; c_ov = ov8; c_busy = busy8; c_prod = 64'(p8);
        case (sel_w)
            4:  begin c_ir = ir4;  c_ov = ov4;  c_busy = busy4;  c_prod = 64'(p4);  end
            16: begin c_ir = ir16; c_ov = ov16; c_busy = busy16; c_prod = 64'(p16); end
            default: ;
        endcase
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_iv(input logic v);
        iv8  = v && (sel_w == 8);
        iv4  = v && (sel_w == 4);
        iv16 = v && (sel_w == 16);
    endtask

    // Reference: interpret operands per mode with plain integer arithmetic, wrap to 2*w bits.
    function automatic logic [63:0] ref_mult(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic s);
        longint ma, mb, p;
        ma = longint'(a) & ((longint'(1) << w) - 1);
        mb = longint'(b) & ((longint'(1) << w) - 1);
        if (s && ma >= (longint'(1) << (w - 1))) ma -= longint'(1) << w;
        if (s && mb >= (longint'(1) << (w - 1))) mb -= longint'(1) << w;
        p = ma * mb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One transaction on the selected instance. Returns the product when out_valid rises,
    // the accept-to-valid latency, and whether busy stayed high throughout.
    // With ordy=1 the output handshake is also completed before returning.
    task automatic xact(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic ordy, input logic poke,
                        output logic [63:0] prod, output int lat, output logic busy_ok);
        int t;
        @(negedge clk);
        a_bus = a; b_bus = b; sm = s; out_ready = ordy;
        set_iv(1'b1);
        t = 0;
        while (!c_ir && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) check("in_ready_timeout", {63'd0, c_ir}, 64'd1);
        @(posedge clk); #1;
        // Operands change after capture; with poke, in_valid stays asserted too.
        a_bus = $urandom; b_bus = $urandom; sm = ~s;
        if (!poke) set_iv(1'b0);
        lat = 0; busy_ok = 1'b1;
        while (!c_ov && lat < 200) begin
            if (!c_busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!c_busy) busy_ok = 1'b0;
        set_iv(1'b0);
        if (lat >= 200) check("out_valid_timeout", {63'd0, c_ov}, 64'd1);
        prod = c_prod;
        if (ordy) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp, input string name);
        vec_t v;
        v.w = w; v.a = a; v.b = b; v.s = s; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        logic [63:0] prod, held;
        int          lat;
        logic        bok;
        logic [31:0] ra, rb;
        int          widths[2];

        rst_n = 1'b0; a_bus = '0; b_bus = '0; sm = 1'b0; out_ready = 1'b1;
        sel_w = 8; set_iv(1'b0);

        #12;
        check("rst_in_ready",  {63'd0, ir8},   64'd1);
        check("rst_out_valid", {63'd0, ov8},   64'd0);
        check("rst_busy",      {63'd0, busy8}, 64'd0);
        check("rst_product",   64'(p8),        64'd0);
        check("rst_out_valid16", {63'd0, ov16}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        add(8,  32'hFF,   32'hFF,   1'b0, 64'hFE01,     "u8_max");
        add(8,  32'h80,   32'h80,   1'b1, 64'h4000,     "s8_min_min");
        add(8,  32'hFD,   32'h05,   1'b1, 64'hFFF1,     "s8_m3_x5");
        add(8,  32'h7F,   32'hFF,   1'b1, 64'hFF81,     "s8_127_m1");
        add(8,  32'h00,   32'hC8,   1'b0, 64'h0,        "u8_zero");
        add(8,  32'h00,   32'hC8,   1'b1, 64'h0,        "s8_zero");
        add(8,  32'hFF,   32'hFF,   1'b1, 64'h0001,     "s8_m1_m1");
        add(8,  32'h06,   32'h07,   1'b0, 64'd42,       "u8_6x7");
        add(4,  32'hF,    32'hF,    1'b0, 64'hE1,       "u4_max");
        add(4,  32'h8,    32'h8,    1'b1, 64'h40,       "s4_min_min");
        add(4,  32'h8,    32'h7,    1'b1, 64'hC8,       "s4_min_max");
        add(16, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE0001, "u16_max");
        add(16, 32'h8000, 32'h8000, 1'b1, 64'h40000000, "s16_min_min");
        add(16, 32'h8000, 32'h7FFF, 1'b1, 64'hC0008000, "s16_min_max");

        foreach (tbl[i]) begin
            sel_w = tbl[i].w;
            xact(tbl[i].a, tbl[i].b, tbl[i].s, 1'b1, 1'b0, prod, lat, bok);
            check({tbl[i].name, "_product"}, prod, tbl[i].exp);
            check({tbl[i].name, "_latency"}, 64'(lat), 64'(tbl[i].w + 1));
            check({tbl[i].name, "_busy"}, {63'd0, bok}, 64'd1);
        end

        // in_valid held high with fresh operands during ACCUM must not disturb the result.
        sel_w = 8;
        xact(32'd10, 32'd11, 1'b0, 1'b1, 1'b1, prod, lat, bok);
        check("ignored_input_product", prod, 64'd110);
        check("ignored_input_latency", 64'(lat), 64'd9);

        // Backpressure: result and flags held while out_ready is low.
        xact(32'd200, 32'd3, 1'b0, 1'b0, 1'b0, held, lat, bok);
        check("bp_product", held, 64'd600);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid_held", {63'd0, c_ov}, 64'd1);
            check("bp_product_held", c_prod, held);
            check("bp_in_ready_low", {63'd0, c_ir}, 64'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", {63'd0, c_ir}, 64'd1);
        check("bp_out_valid_after", {63'd0, c_ov}, 64'd0);

        // Reset while accumulating row 4: everything drops at once, no partial result.
        @(negedge clk);
        a_bus = 32'd9; b_bus = 32'd9; sm = 1'b0; set_iv(1'b1);
        @(posedge clk); #1;
        set_iv(1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, c_ov},   64'd0);
        check("arst_busy",      {63'd0, c_busy}, 64'd0);
        check("arst_product",   c_prod,          64'd0);
        check("arst_in_ready",  {63'd0, c_ir},   64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", {63'd0, c_ir}, 64'd1);
        xact(32'd6, 32'd7, 1'b0, 1'b1, 1'b0, prod, lat, bok);
        check("post_rst_6x7", prod, 64'd42);

        // Random sweep against the arithmetic reference.
        widths[0] = 4; widths[1] = 16;
        foreach (widths[wi]) begin
            sel_w = widths[wi];
            for (int m = 0; m < 2; m++) begin
                for (int n = 0; n < 1000; n++) begin
                    ra = $urandom & ((32'd1 << sel_w) - 32'd1);
                    rb = $urandom & ((32'd1 << sel_w) - 32'd1);
                    xact(ra, rb, m[0], 1'b1, 1'b0, prod, lat, bok);
                    if (prod !== ref_mult(sel_w, ra, rb, m[0]))
                        $display("FAIL rand w=%0d s=%0d a=0x%0h b=0x%0h: got 0x%0h, expected 0x%0h",
                                 sel_w, m, ra, rb, prod, ref_mult(sel_w, ra, rb, m[0]));
                    else
                        n_pass++;
                    n_total++;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
